sb_cfg_param: RTL and testbench



---
 rtl/sb_cfg_param.sv | 114 +++++++++++
 tb/tb_sb_cfg_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg_param.sv
// sb_cfg_param: configurable switch-block corner with a serially loaded
// shadow frame, parity-checked commit into the active routing configuration,
// and 2-bit-select routing muxes on the low NUM_PINS tracks of each side.
module sb_cfg_param #(
  parameter int CHAN_WIDTH = 10,
  parameter int NUM_PINS   = 7
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  cfg_commit,
  input  logic                  cfg_parity,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [NUM_PINS-1:0]   bottom_pin_in,
  input  logic [NUM_PINS-1:0]   left_pin_in,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic                  ccff_tail,
  output logic                  cfg_valid,
  output logic                  cfg_error,
  output logic                  cfg_busy
);

  // Frame length: two select bits per mux, NUM_PINS muxes on each of two sides.
  localparam int N  = 4 * NUM_PINS;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N + 1);

  // Bit k of sh_r / active_r holds frame bit sh[k] / active[k].
  logic [N-1:0]  sh_r;
  logic [N-1:0]  active_r;
  logic [CW-1:0] cnt_r;
  logic          valid_r;
  logic          error_r;

  // Even parity of a whole frame; compared against the supplied cfg_parity.
  function automatic logic parity_f(input logic [N-1:0] v);
    return ^v;
  endfunction

  // Routing mux: 01 selects the pin, 10 the track, anything else drives 0.
  // Gated to 0 until a configuration has been committed.
  function automatic logic mux_f(input logic en, input logic [1:0] sel,
                                 input logic pin, input logic trk);
    logic y;
    y = 1'b0;
    if (en) begin
      case (sel)
        2'b01:   y = pin;
        2'b10:   y = trk;
        default: y = 1'b0;
      endcase
    end else begin
      y = 1'b0;
    end
    return y;
  endfunction

  // Shadow shift, bit counting and commit check; reset beats everything.
  // A commit coinciding with a shift is rejected but the shift still happens.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      sh_r     <= '0;
      active_r <= '0;
      cnt_r    <= '0;
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
    end else if (ccff_en) begin
      sh_r <= {sh_r[N-2:0], ccff_head};
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (cfg_commit) begin
        error_r <= 1'b1;
      end
    end else if (cfg_commit) begin
      cnt_r <= '0;
      if ((cnt_r == CNT_FULL) && (parity_f(sh_r) == cfg_parity)) begin
        active_r <= sh_r;
        valid_r  <= 1'b1;
        error_r  <= 1'b0;
      end else begin
        error_r  <= 1'b1;
      end
    end
  end

  assign ccff_tail = sh_r[N-1];
  assign cfg_valid = valid_r;
  assign cfg_error = error_r;
  assign cfg_busy  = (cnt_r != '0);

  // Configured tracks: bottom mux m=g uses active[2g],[2g+1]; left mux uses m=NUM_PINS+g.
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_mux
    assign chany_bottom_out[g] = mux_f(valid_r,
                                       {active_r[2*g], active_r[2*g+1]},
                                       bottom_pin_in[g],
                                       chanx_left_in[(g+1)%CHAN_WIDTH]);
    assign chanx_left_out[g]   = mux_f(valid_r,
                                       {active_r[2*(g+NUM_PINS)], active_r[2*(g+NUM_PINS)+1]},
                                       left_pin_in[g],
                                       chany_bottom_in[(g+CHAN_WIDTH-1)%CHAN_WIDTH]);
  end

  // Remaining tracks are fixed wires that pass through regardless of configuration.
  for (genvar g = NUM_PINS; g < CHAN_WIDTH; g++) begin : g_short
    assign chany_bottom_out[g] = chanx_left_in[(g+1)%CHAN_WIDTH];
    assign chanx_left_out[g]   = chany_bottom_in[g-1];
  end

endmodule

// File: tb/tb_sb_cfg_param.sv
// tb_sb_cfg_param: randomized scoreboard bench for sb_cfg_param.
// The stimulus process updates a frame-level model at each edge and queues the
// expected outputs; a negedge monitor pops and compares them.
module tb_sb_cfg_param;

  localparam int W = 10;
  localparam int P = 7;
  localparam int N = 4 * P;

  logic         prog_clk = 1'b0;
  logic         pReset, ccff_head, ccff_en, cfg_commit, cfg_parity;
  logic [W-1:0] chany_bottom_in, chanx_left_in;
  logic [P-1:0] bottom_pin_in, left_pin_in;
  logic [W-1:0] chany_bottom_out, chanx_left_out;
  logic         ccff_tail, cfg_valid, cfg_error, cfg_busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] bot;
    logic [W-1:0] left;
    logic         tail;
    logic         valid;
    logic         err;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit m_sh[N];
  bit m_act[N];
  int m_cnt;
  bit m_valid;
  bit m_err;

  sb_cfg_param #(.CHAN_WIDTH(W), .NUM_PINS(P)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .cfg_commit(cfg_commit), .cfg_parity(cfg_parity),
    .chany_bottom_in(chany_bottom_in), .chanx_left_in(chanx_left_in),
    .bottom_pin_in(bottom_pin_in), .left_pin_in(left_pin_in),
    .chany_bottom_out(chany_bottom_out), .chanx_left_out(chanx_left_out),
    .ccff_tail(ccff_tail), .cfg_valid(cfg_valid), .cfg_error(cfg_error),
    .cfg_busy(cfg_busy)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_parity();
    bit p;
    p = 1'b0;
    for (int k = 0; k < N; k++) p ^= m_sh[k];
    return p;
  endfunction

  // Apply the documented edge rules for one clock edge.
  function automatic void model_edge(bit r, bit en, bit head, bit com, bit par);
    if (!r) begin
      for (int k = 0; k < N; k++) begin m_sh[k] = 0; m_act[k] = 0; end
      m_cnt = 0; m_valid = 0; m_err = 0;
    end else if (en) begin
      for (int k = N - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
      m_sh[0] = head;
      if (m_cnt < N + 1) m_cnt++;
      if (com) m_err = 1;
    end else if (com) begin
      if (m_cnt == N && m_parity() == par) begin
        for (int k = 0; k < N; k++) m_act[k] = m_sh[k];
        m_valid = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
      m_cnt = 0;
    end
  endfunction

  function automatic bit route(int m, bit pin, bit trk);
    int sel;
    sel = 2 * int'(m_act[2*m]) + int'(m_act[2*m+1]);
    if (!m_valid) return 0;
    if (sel == 1) return pin;
    if (sel == 2) return trk;
    return 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < W; i++) begin
      if (i < P) begin
        e.bot[i]  = route(i, bottom_pin_in[i], chanx_left_in[(i+1)%W]);
        e.left[i] = route(P + i, left_pin_in[i], chany_bottom_in[(i+W-1)%W]);
      end else begin
        e.bot[i]  = chanx_left_in[(i+1)%W];
        e.left[i] = chany_bottom_in[i-1];
      end
    end
    e.tail  = m_sh[N-1];
    e.valid = m_valid;
    e.err   = m_err;
    e.busy  = (m_cnt != 0);
    return e;
  endfunction

  // One clock: drive controls, take the edge, randomize data, queue expectation.
  task automatic step(input bit r, input bit en, input bit head, input bit com, input bit par);
    pReset = r; ccff_en = en; ccff_head = head; cfg_commit = com; cfg_parity = par;
    @(posedge prog_clk);
    model_edge(r, en, head, com, par);
    #1;
    chany_bottom_in = W'($urandom);
    chanx_left_in   = W'($urandom);
    bottom_pin_in   = P'($urandom);
    left_pin_in     = P'($urandom);
    exp_q.push_back(model_out());
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'(($urandom) & 1), 1'b0, 1'(($urandom) & 1));
  endtask

  // Shift nbits so that, for nbits == N, sh[k] ends up equal to v[k].
  task automatic shift_frame(input logic [N-1:0] v, input int nbits);
    for (int j = 0; j < nbits; j++)
      step(1'b1, 1'b1, (j < N) ? v[N-1-j] : 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit(input bit par);
    step(1'b1, 1'b0, 1'b0, 1'b1, par);
  endtask

  // Directed probe of bottom mux 0 after the monitor has compared this cycle.
  task automatic probe(input string name, input bit pin, input bit trk, input bit exp);
    @(negedge prog_clk);
    #1;
    bottom_pin_in[0] = pin;
    chanx_left_in[1] = trk;
    #1;
    chk(name, 32'(chany_bottom_out[0]), 32'(exp));
  endtask

  // Monitor: compare queued expectation against DUT outputs mid-cycle.
  always @(negedge prog_clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("chany_bottom_out", 32'(chany_bottom_out), 32'(e.bot));
      chk("chanx_left_out",   32'(chanx_left_out),   32'(e.left));
      chk("ccff_tail",        32'(ccff_tail),        32'(e.tail));
      chk("cfg_valid",        32'(cfg_valid),        32'(e.valid));
      chk("cfg_error",        32'(cfg_error),        32'(e.err));
      chk("cfg_busy",         32'(cfg_busy),         32'(e.busy));
    end
  end

  initial begin
    logic [N-1:0] v;
    int wait_cnt;
    pReset = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0; cfg_parity = 1'b0;
    chany_bottom_in = '0; chanx_left_in = '0; bottom_pin_in = '0; left_pin_in = '0;

    // Reset and idle: gated muxes at 0, shorts still pass.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) idle();

    // Frame with sel 01 on bottom mux 0 -> pin.
    v = '0; v[1] = 1'b1;
    shift_frame(v, N); commit(1'b1); idle();
    probe("pin_sel_hi", 1'b1, 1'b0, 1'b1);
    probe("pin_sel_lo", 1'b0, 1'b1, 1'b0);

    // Frame with sel 10 on bottom mux 0 -> track.
    v = '0; v[0] = 1'b1;
    shift_frame(v, N); commit(1'b1); idle();
    probe("trk_sel_hi", 1'b0, 1'b1, 1'b1);
    probe("trk_sel_lo", 1'b1, 1'b0, 1'b0);

    // Bad commits: short frame, long frame, wrong parity.
    v = N'($urandom);
    shift_frame(v, N - 1); commit(m_parity()); idle();
    shift_frame(v, N + 1); commit(m_parity()); idle();
    shift_frame(v, N);     commit(~m_parity()); idle();

    // Random good frames.
    repeat (4) begin
      v = N'($urandom);
      shift_frame(v, N); commit(^v); repeat (2) idle();
    end

    // Shadow shifting leaves routing alone; tail emits first bit after N shifts.
    v = N'($urandom);
    shift_frame(v, 10); repeat (2) idle();
    shift_frame(N'($urandom), N - 10 + 2);
    commit(m_parity()); idle();

    // Reset mid-frame with shift and commit asserted, then a clean frame.
    shift_frame(N'($urandom), 14);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1); idle();
    v = N'($urandom);
    shift_frame(v, N); commit(^v); idle();

    // Commit together with the 28th shift is rejected; lone commit then succeeds.
    v = N'($urandom);
    shift_frame(v, N - 1);
    step(1'b1, 1'b1, v[0], 1'b1, ^v);
    idle();
    commit(m_parity()); idle();

    // Random mixed traffic.
    for (int c = 0; c < 400; c++) begin
      bit r, en, com;
      r   = ($urandom_range(0, 49) != 0);
      en  = ($urandom_range(0, 3) != 0);
      com = ($urandom_range(0, 19) == 0);
      if (com && $urandom_range(0, 1) == 1) en = 1'b0;
      if (!en && !com && $urandom_range(0, 1) == 1)
        step(r, 1'b0, 1'b0, 1'b1, m_parity());
      else
        step(r, en, 1'(($urandom) & 1), com, 1'(($urandom) & 1));
    end

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(posedge prog_clk);
      wait_cnt++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
